// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute controller for the 16-bit, 4-bit-opcode CPU: owns the PC and sequences IL/RW/FS/MD/MR/MW.
// Optional feature: define ILLEGAL_TRAP_EN to halt on opcode 1110 and raise the sticky illegal_op flag.
module cpu_control_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic [7:0]          imm,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic [PC_WIDTH-1:0] pc,
  output logic                IL,
  output logic                RW,
  output logic [3:0]          FS,
  output logic                MD,
  output logic                MR,
  output logic                MW,
  output logic                halted,
  output logic                illegal_op
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } state_t;

  localparam logic [3:0] OP_LD  = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b1011;
  localparam logic [3:0] OP_BZ  = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;
  localparam logic [3:0] OP_RSV = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);

  state_t                state;
  state_t                next_state;
  logic                  idle_done;
  logic [3:0]            op_q;
  logic                  op_is_alu;
  logic [PC_WIDTH-1:0]   imm_sext;
  logic [PC_WIDTH-1:0]   imm_zext;

  // Branch offset is sign-extended, jump target zero-extended, both fitted to the PC width.
  generate
    if (PC_WIDTH > 8) begin : g_wide_pc
      assign imm_sext = {{(PC_WIDTH-8){imm[7]}}, imm};
      assign imm_zext = {{(PC_WIDTH-8){1'b0}}, imm};
    end else if (PC_WIDTH == 8) begin : g_byte_pc
      assign imm_sext = imm;
      assign imm_zext = imm;
    end else begin : g_narrow_pc
      assign imm_sext = imm[PC_WIDTH-1:0];
      assign imm_zext = imm[PC_WIDTH-1:0];
    end
  endgenerate

  assign op_is_alu = (op_q >= 4'd1) && (op_q <= 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idle_done <= 1'b0;
      op_q      <= 4'd0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        idle_done <= 1'b1;
      end
      if (state == DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // IDLE spends one full cycle after reset release so the first FETCH lands on the second edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   next_state = idle_done ? FETCH : IDLE;
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LD, OP_ST: next_state = MEM;
          OP_HLT:       next_state = HALT;
`ifdef ILLEGAL_TRAP_EN
          OP_RSV:       next_state = HALT;
`endif
          default:      next_state = EXEC;
        endcase
      end
      EXEC:   next_state = FETCH;
      MEM:    next_state = mem_ready ? FETCH : MEM;
      HALT:   next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_INIT;
    end else if (state == FETCH) begin
      pc <= pc + 1'b1;
    end else if (state == EXEC) begin
      if (op_q == OP_BZ && zero_flag) begin
        pc <= pc + imm_sext;
      end else if (op_q == OP_JMP) begin
        pc <= imm_zext;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_op <= 1'b0;
    end else if (state == DECODE && opcode == OP_RSV) begin
      illegal_op <= 1'b1;
    end
  end
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    IL     = 1'b0;
    RW     = 1'b0;
    FS     = 4'd0;
    MD     = 1'b0;
    MR     = 1'b0;
    MW     = 1'b0;
    halted = 1'b0;
    case (state)
      FETCH: IL = 1'b1;
      EXEC: begin
        if (op_is_alu) begin
          FS = op_q;
          RW = 1'b1;
        end
      end
      MEM: begin
        // A load writes back in the same cycle the memory reports completion.
        if (op_q == OP_LD) begin
          MR = 1'b1;
          RW = mem_ready;
          MD = mem_ready;
        end else begin
          MW = 1'b1;
        end
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: directed scenarios plus random instruction streams
// checked against an instruction-level model of PC and per-cycle control strobes.
module tb_cpu_control_sequencer;

  localparam int PCW = 8;
  localparam int MOD = 256;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     opcode = 4'd0;
  logic [7:0]     imm = 8'd0;
  logic           zero_flag = 1'b0;
  logic           mem_ready = 1'b0;
  logic [PCW-1:0] pc;
  logic           IL, RW, MD, MR, MW, halted, illegal_op;
  logic [3:0]     FS;
  logic [9:0]     obs;

  int   vectors = 0;
  int   miscompares = 0;
  int   model_pc = 0;
  logic model_illegal = 1'b0;

  cpu_control_sequencer #(.PC_WIDTH(PCW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .imm(imm), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .pc(pc), .IL(IL), .RW(RW), .FS(FS), .MD(MD), .MR(MR),
    .MW(MW), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {IL, RW, FS, MD, MR, MW, halted};

  function automatic logic [9:0] pack(input logic il, input logic rw, input logic [3:0] fs,
                                      input logic md, input logic mr, input logic mw, input logic hl);
    return {il, rw, fs, md, mr, mw, hl};
  endfunction

  // One instruction from FETCH entry to the edge that leaves its last cycle; optional reset mid-MEM.
  task automatic run_instr(input logic [3:0] op, input logic [7:0] im, input logic zf,
                           input int waits, input bit abort_mid, input string tag);
    logic [9:0] exp;
    logic [PCW-1:0] exp_pc;
    int off;
    off = (im >= 8'd128) ? int'(im) - 256 : int'(im);

    @(negedge clk);
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    opcode = op;
    imm = im;
    #1;
    exp_pc = model_pc[PCW-1:0];
    vectors++;
    if (obs !== pack(1, 0, 4'd0, 0, 0, 0, 0) || pc !== exp_pc || illegal_op !== model_illegal) begin
      miscompares++;
      $display("[TB] FAIL %s fetch: out=%b pc=%h ill=%b, want out=%b pc=%h ill=%b",
               tag, obs, pc, illegal_op, pack(1, 0, 4'd0, 0, 0, 0, 0), exp_pc, model_illegal);
    end
    model_pc = (model_pc + 1) % MOD;

    @(negedge clk);
    #1;
    exp_pc = model_pc[PCW-1:0];
    vectors++;
    if (obs !== 10'd0 || pc !== exp_pc) begin
      miscompares++;
      $display("[TB] FAIL %s decode: out=%b pc=%h, want out=%b pc=%h", tag, obs, pc, 10'd0, exp_pc);
    end

    if (op == 4'd15 || (op == 4'd14 && TRAP)) begin
      @(negedge clk);
      #1;
      if (op == 4'd14) model_illegal = 1'b1;
      vectors++;
      if (obs !== pack(0, 0, 4'd0, 0, 0, 0, 1) || pc !== exp_pc || illegal_op !== model_illegal) begin
        miscompares++;
        $display("[TB] FAIL %s halt: out=%b pc=%h ill=%b, want out=%b pc=%h ill=%b",
                 tag, obs, pc, illegal_op, pack(0, 0, 4'd0, 0, 0, 0, 1), exp_pc, model_illegal);
      end
    end else if (op == 4'd10 || op == 4'd11) begin
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        mem_ready = (i == waits);
        #1;
        exp = (op == 4'd10) ? pack(0, i == waits, 4'd0, i == waits, 1, 0, 0) : pack(0, 0, 4'd0, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp || pc !== exp_pc) begin
          miscompares++;
          $display("[TB] FAIL %s mem[%0d]: out=%b pc=%h, want out=%b pc=%h", tag, i, obs, pc, exp, exp_pc);
        end
        if (abort_mid && i == 1) begin
          reset = 1'b0;
          #1;
          model_pc = 0;
          model_illegal = 1'b0;
          vectors++;
          if (obs !== 10'd0 || pc !== 8'd0 || illegal_op !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s async_reset: out=%b pc=%h ill=%b, want out=0 pc=00 ill=0",
                     tag, obs, pc, illegal_op);
          end
          return;
        end
      end
    end else begin
      @(negedge clk);
      zero_flag = zf;
      #1;
      exp = (op >= 4'd1 && op <= 4'd9) ? pack(0, 1, op, 0, 0, 0, 0) : 10'd0;
      vectors++;
      if (obs !== exp || pc !== exp_pc) begin
        miscompares++;
        $display("[TB] FAIL %s exec: out=%b pc=%h, want out=%b pc=%h", tag, obs, pc, exp, exp_pc);
      end
      if (op == 4'd12 && zf) model_pc = ((model_pc + off) % MOD + MOD) % MOD;
      if (op == 4'd13) model_pc = int'(im);
    end
  endtask

  // Release reset and confirm the controller idles for one edge before fetching.
  task automatic release_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (obs !== 10'd0 || pc !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_release: out=%b pc=%h, want out=0 pc=00", obs, pc);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (obs !== 10'd0 || pc !== 8'd0 || illegal_op !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: out=%b pc=%h ill=%b, want out=0 pc=00 ill=0", obs, pc, illegal_op);
    end
    release_reset();
    run_instr(4'd13, 8'h20, 1'b0, 0, 1'b0, "pre_ld_jmp");
    run_instr(4'd10, 8'h00, 1'b0, 3, 1'b1, "ld_abort");
    #2;
    release_reset();
  endtask

  task automatic test_alu();
    run_instr(4'd3, 8'h5A, 1'b0, 0, 1'b0, "alu_0011");
    run_instr(4'd0, 8'h00, 1'b0, 0, 1'b0, "nop");
  endtask

  task automatic test_load_store();
    run_instr(4'd10, 8'h00, 1'b0, 2, 1'b0, "ld_wait2");
    run_instr(4'd11, 8'h00, 1'b0, 1, 1'b0, "st_wait1");
    run_instr(4'd11, 8'h00, 1'b0, 0, 1'b0, "st_wait0");
  endtask

  task automatic test_branch();
    run_instr(4'd13, 8'hFE, 1'b0, 0, 1'b0, "jmp_fe");
    run_instr(4'd12, 8'h03, 1'b1, 0, 1'b0, "bz_taken_wrap");
    run_instr(4'd13, 8'hFE, 1'b0, 0, 1'b0, "jmp_fe2");
    run_instr(4'd12, 8'h03, 1'b0, 0, 1'b0, "bz_not_taken");
    run_instr(4'd12, 8'hF0, 1'b1, 0, 1'b0, "bz_backward");
    run_instr(4'd13, 8'h40, 1'b0, 0, 1'b0, "jmp_40");
    run_instr(4'd0, 8'h00, 1'b0, 0, 1'b0, "after_jmp");
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, TRAP ? 13 : 14));
      run_instr(op, 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0, "random");
    end
  endtask

  task automatic test_illegal();
    run_instr(4'd14, 8'h00, 1'b0, 0, 1'b0, "op_1110");
    if (TRAP) begin
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      model_pc = 0;
      model_illegal = 1'b0;
      release_reset();
    end
    run_instr(4'd0, 8'h00, 1'b0, 0, 1'b0, "after_1110");
  endtask

  task automatic test_halt();
    logic [PCW-1:0] exp_pc;
    run_instr(4'd15, 8'h00, 1'b0, 0, 1'b0, "hlt");
    exp_pc = model_pc[PCW-1:0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      vectors++;
      if (obs !== pack(0, 0, 4'd0, 0, 0, 0, 1) || pc !== exp_pc) begin
        miscompares++;
        $display("[TB] FAIL halt_hold[%0d]: out=%b pc=%h, want out=%b pc=%h",
                 i, obs, pc, pack(0, 0, 4'd0, 0, 0, 0, 1), exp_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_random();
    test_illegal();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
